// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end definitions: fetch-buffer entry layout and the reset PC.
package cpu_defs;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;

endpackage

// File: rtl/inst_fifo_perf.sv
// Free-running stall/empty cycle counters for the instruction fetch buffer.
// Instantiated by inst_fifo only when INST_FIFO_PERF_EN is defined.
module inst_fifo_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_full,
    input  logic        i_empty,
    output logic [31:0] o_stall_full_cycles,
    output logic [31:0] o_empty_cycles
);

    logic [31:0] r_stall_full_cycles;
    logic [31:0] r_empty_cycles;

    // Counters wrap naturally at 2^32 and are deliberately untouched by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_full_cycles <= '0;
            r_empty_cycles      <= '0;
        end else begin
            if (i_full)
                r_stall_full_cycles <= r_stall_full_cycles + 32'd1;
            if (i_empty)
                r_empty_cycles <= r_empty_cycles + 32'd1;
        end
    end

    assign o_stall_full_cycles = r_stall_full_cycles;
    assign o_empty_cycles      = r_empty_cycles;

endmodule

// File: rtl/inst_fifo.sv
// Dual-write / dual-read instruction fetch buffer between fetch and decode.
// Optional perf counters are enabled with `define INST_FIFO_PERF_EN.
module inst_fifo
    import cpu_defs::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     F_inst_data_ok1,
    input  logic                     F_inst_data_ok2,
    input  logic [31:0]              F_inst1,
    input  logic [31:0]              F_inst2,
    input  logic [31:0]              F_pc1,
    input  logic [31:0]              F_pc2,
    input  logic                     D_read_en1,
    input  logic                     D_read_en2,
    output logic                     D_valid1,
    output logic                     D_valid2,
    output logic [31:0]              D_inst1,
    output logic [31:0]              D_inst2,
    output logic [31:0]              D_pc1,
    output logic [31:0]              D_pc2,
    output logic                     D_fifo_full,
    output logic [$clog2(DEPTH):0]   count
`ifdef INST_FIFO_PERF_EN
    ,
    output logic [31:0]              stall_full_cycles,
    output logic [31:0]              empty_cycles
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    fifo_entry_t     r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic [1:0]      w_wr_n;
    logic [1:0]      w_rd_n;
    logic [1:0]      w_wr_eff;
    logic [SW-1:0]   w_sum;
    logic [PW-1:0]   w_head1;
    logic [PW-1:0]   w_tail1;
    fifo_entry_t     w_e1;
    fifo_entry_t     w_e2;

    // Transfer counts; the overflow guard drops the whole write, never half of it.
    always_comb begin
        w_wr_n = 2'd0;
        w_rd_n = 2'd0;
        if (F_inst_data_ok1)
            w_wr_n = F_inst_data_ok2 ? 2'd2 : 2'd1;
        if (D_read_en1 && D_read_en2 && (r_count >= CW'(2)))
            w_rd_n = 2'd2;
        else if (D_read_en1 && (r_count >= CW'(1)))
            w_rd_n = 2'd1;
        w_sum    = SW'(r_count) + SW'(w_wr_n) - SW'(w_rd_n);
        w_wr_eff = (w_sum <= SW'(DEPTH)) ? w_wr_n : 2'd0;
    end

    assign w_head1 = r_head + PW'(1);
    assign w_tail1 = r_tail + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_rd_n);
            r_tail  <= r_tail + PW'(w_wr_eff);
            r_count <= r_count + CW'(w_wr_eff) - CW'(w_rd_n);
        end
    end

    // Storage array carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!flush && (w_wr_eff != 2'd0))
            r_mem[r_tail] <= '{pc: F_pc1, inst: F_inst1};
        if (!flush && (w_wr_eff == 2'd2))
            r_mem[w_tail1] <= '{pc: F_pc2, inst: F_inst2};
    end

    assign w_e1 = r_mem[r_head];
    assign w_e2 = r_mem[w_head1];

    assign D_valid1    = (r_count >= CW'(1));
    assign D_valid2    = (r_count >= CW'(2));
    assign D_inst1     = D_valid1 ? w_e1.inst : 32'd0;
    assign D_pc1       = D_valid1 ? w_e1.pc   : 32'd0;
    assign D_inst2     = D_valid2 ? w_e2.inst : 32'd0;
    assign D_pc2       = D_valid2 ? w_e2.pc   : 32'd0;
    assign D_fifo_full = (r_count > CW'(DEPTH - 2));
    assign count       = r_count;

`ifdef INST_FIFO_PERF_EN
    inst_fifo_perf u_perf (
        .clk                 (clk),
        .rst                 (rst),
        .i_full              (D_fifo_full),
        .i_empty             ((r_count == CW'(0)) && !flush),
        .o_stall_full_cycles (stall_full_cycles),
        .o_empty_cycles      (empty_cycles)
    );
`endif

endmodule
